ifu_fetch: RTL and testbench

Instruction fetch unit and initiator side of the instruction-memory interface. It generates sequential PCs, issues req/gnt requests to a variable-latency imem, matches in-order responses to their PCs, and buffers {pc, instr} pairs in a small queue for decode under valid/ready. Supports redirect (branch/jump/trap) with flush and discard of stale in-flight responses.

---
 rtl/ifu_fetch.sv | 118 +++++++++++
 tb/tb_ifu_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: sequential PC generator and req/gnt imem initiator.
// Matches in-order responses to PCs and queues {pc, instr} for decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t        q [DEPTH];
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW:0]   credit;
  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // in-flight requests hold a queue slot, even ones that will be discarded
  assign credit = {1'b0, outstanding} + {1'b0, count};
  assign imem_req = rstn && !redirect_valid
                    && (credit < LIMIT);
  assign imem_addr = fetch_pc;

  assign grant = imem_req && imem_gnt;
  assign resp  = imem_rvalid && (outstanding != '0);
  assign push  = resp && (discard == '0)
                 && !redirect_valid;

  assign instr_valid = (count != '0);
  assign pop = instr_valid && instr_ready
               && !redirect_valid;

  assign instr    = instr_valid ? q[head].word : '0;
  assign instr_pc = instr_valid ? q[head].pc   : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant)
                     - CW'(resp);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= outstanding - CW'(resp);
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (grant)
          fetch_pc <= fetch_pc + 32'd4;
        if (resp && (discard != '0))
          discard <= discard - CW'(1);
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          tail    <= nxt(tail);
        end
        if (pop)
          head <= nxt(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      q[tail] <= '{pc: resp_pc, word: imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(imem_rvalid && (outstanding == '0)));
      assert (!(push && (count == FULL)));
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch with a fixed-latency
// in-order imem model; a second instance covers a wrapping RESET_PC.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        u1_req;
  logic [31:0] u1_addr;
  logic        u1_rvalid;
  logic [31:0] u1_rdata;
  logic        u1_valid;
  logic [31:0] u1_instr;
  logic [31:0] u1_pc;
  logic        u1_gp;
  logic [31:0] u1_ap;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (u1_req),
    .imem_addr      (u1_addr),
    .imem_gnt       (1'b1),
    .imem_rvalid    (u1_rvalid),
    .imem_rdata     (u1_rdata),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .instr_valid    (u1_valid),
    .instr          (u1_instr),
    .instr_pc       (u1_pc),
    .instr_ready    (1'b1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  exp_t  exp_q [$];
  pend_t pend  [$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  int    lat    = 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h",
                  nm, act, req);
  endtask

  task automatic expect_seq(input logic [31:0] pc0,
                            input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = pc0 + 32'(4 * i);
      exp_q.push_back('{pc: p, w: p});
    end
  endtask

  task automatic drain(input int lim,
                       input string nm,
                       output int k);
    k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      @(negedge clk);
      #4;
      k++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    pend.delete();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // imem model: rdata = address, response lat cycles after grant
  always @(negedge clk) begin
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].a;
      pend.delete(0);
    end
    if (imem_req && imem_gnt)
      pend.push_back('{a: imem_addr, due: cyc + lat});
    u1_rvalid = u1_gp;
    u1_rdata  = u1_ap;
    u1_gp     = u1_req;
    u1_ap     = u1_addr;
  end

  // scoreboard monitor: a redirect voids the pop in its cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rstn && instr_valid && instr_ready
          && !redirect_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.w);
      end
    end
  end

  // wrapping RESET_PC instance, free running with 1-cycle memory
  initial begin
    logic [31:0] e [3];
    int got;
    int k;
    got = 0;
    k = 0;
    e[0] = 32'hFFFF_FFF8;
    e[1] = 32'hFFFF_FFFC;
    e[2] = 32'h0000_0000;
    @(posedge rstn);
    while (got < 3 && k < 12) begin
      #3;
      if (u1_valid) begin
        chk("t5_pc", u1_pc, e[got]);
        chk("t5_instr", u1_instr, e[got]);
        got++;
      end
      @(negedge clk);
      k++;
    end
    chk("t5_count", got, 3);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int g;
    rstn = 1'b0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    u1_rvalid = 1'b0;
    u1_rdata = 32'h0;
    u1_gp = 1'b0;
    u1_ap = 32'h0;

    // reset state and streaming with 1-cycle memory
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    @(negedge clk);
    expect_seq(32'h0, 6);
    rstn = 1'b1;
    #2;
    chk("t1_req", imem_req, 1);
    chk("t1_valid_c0", instr_valid, 0);
    @(negedge clk);
    #2;
    chk("t1_valid_c1", instr_valid, 0);
    @(negedge clk);
    #2;
    chk("t1_valid_c2", instr_valid, 1);
    drain(20, "t1_drain", k);
    chk("t1_rate", k, 5);

    // backpressure: credits stop fetch at four
    instr_ready = 1'b0;
    do_reset();
    g = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (imem_req && imem_gnt) g++;
      @(negedge clk);
    end
    chk("t2_grants", g, 4);
    #2;
    chk("t2_req", imem_req, 0);
    chk("t2_valid", instr_valid, 1);
    chk("t2_head", instr_pc, 32'h0);
    chk("t2_addr", imem_addr, 32'h10);
    expect_seq(32'h0, 6);
    instr_ready = 1'b1;
    drain(30, "t2_drain", k);

    // grant stall holds the PC
    do_reset();
    expect_seq(32'h0, 5);
    @(negedge clk);
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t3_req", imem_req, 1);
      chk("t3_addr", imem_addr, 32'h8);
      @(negedge clk);
    end
    imem_gnt = 1'b1;
    drain(30, "t3_drain", k);

    // redirect with two stale responses in flight
    lat = 3;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    expect_seq(32'h100, 3);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("t4_valid", instr_valid, 0);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_req", imem_req, 1);
    drain(30, "t4_drain", k);

    // back-to-back redirects mid-stream, response in redirect cycle
    lat = 1;
    do_reset();
    expect_seq(32'h0, 2);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    exp_q.delete();
    @(negedge clk);
    redirect_pc = 32'h200;
    expect_seq(32'h200, 2);
    #2;
    chk("t4b_valid_r1", instr_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("t4b_valid_r2", instr_valid, 0);
    chk("t4b_addr", imem_addr, 32'h200);
    drain(30, "t4b_drain", k);

    // reset with requests in flight and entries queued
    instr_ready = 1'b0;
    lat = 3;
    do_reset();
    repeat (4) @(negedge clk);
    #2;
    chk("t6_pre_valid", instr_valid, 1);
    chk("t6_pre_pc", instr_pc, 32'h0);
    @(negedge clk);
    rstn = 1'b0;
    exp_q.delete();
    #2;
    chk("t6_rst_req", imem_req, 0);
    @(negedge clk);
    pend.delete();
    lat = 1;
    rstn = 1'b1;
    instr_ready = 1'b1;
    expect_seq(32'h0, 3);
    #2;
    chk("t6_valid", instr_valid, 0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req", imem_req, 1);
    drain(30, "t6_drain", k);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
